// File: rtl/paddsb_seq_ctrl_pkg.sv
// paddsb_pkg: definitions shared by the packed saturating add/subtract
// sequencer.
//   state_t            - controller states (IDLE / CALC / DONE)
//   LANE_W             - width of one signed lane
//   SAT_POS / SAT_NEG  - clamp values for positive / negative overflow
package paddsb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LANE_W = 4;

  localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

endpackage

// File: rtl/paddsb_seq_ctrl_if.sv
// paddsb_seq_ctrl_if: request/response bundle for paddsb_seq_ctrl.
//   in_valid/in_ready   - operation handshake (A, B, sub travel with it)
//   out_valid/out_ready - result handshake (Sum travels with it)
//   sat_flags           - per-lane saturation flags, present only when
//                         PADDSB_SAT_FLAG_EN is defined
// Modports: master = requester/consumer side, slave = the sequencer.
interface paddsb_seq_ctrl_if #(
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [4*LANES-1:0] A;
  logic [4*LANES-1:0] B;
  logic               sub;
  logic               out_valid;
  logic               out_ready;
  logic [4*LANES-1:0] Sum;
`ifdef PADDSB_SAT_FLAG_EN
  logic [LANES-1:0]   sat_flags;
`endif

  modport master (
    output in_valid, A, B, sub, out_ready,
`ifdef PADDSB_SAT_FLAG_EN
    input  sat_flags,
`endif
    input  in_ready, out_valid, Sum
  );

  modport slave (
    input  in_valid, A, B, sub, out_ready,
`ifdef PADDSB_SAT_FLAG_EN
    output sat_flags,
`endif
    output in_ready, out_valid, Sum
  );
endinterface

// File: rtl/paddsb_lane.sv
// paddsb_lane: one 4-bit two's-complement add/subtract with signed
// saturation. Purely combinational.
//   a, b - lane operands
//   sub  - 1: a-b, 0: a+b
//   y    - saturated result
//   sat  - 1 when the result was clamped
module paddsb_lane
  import paddsb_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  output logic [LANE_W-1:0] y,
  output logic              sat
);

  logic [LANE_W-1:0] raw;
  logic a_neg, b_neg, r_neg;

  assign raw   = sub ? (a - b) : (a + b);
  assign a_neg = a[LANE_W-1];
  assign b_neg = b[LANE_W-1];
  assign r_neg = raw[LANE_W-1];

  // Overflow is only possible when the effective operand signs agree;
  // for subtract, b's effective sign is inverted.
  always_comb begin
    y   = raw;
    sat = 1'b0;
    if (!sub) begin
      if (!a_neg && !b_neg && r_neg) begin
        y   = SAT_POS;
        sat = 1'b1;
      end else if (a_neg && b_neg && !r_neg) begin
        y   = SAT_NEG;
        sat = 1'b1;
      end
    end else begin
      if (!a_neg && b_neg && r_neg) begin
        y   = SAT_POS;
        sat = 1'b1;
      end else if (a_neg && !b_neg && !r_neg) begin
        y   = SAT_NEG;
        sat = 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddsb_seq_ctrl.sv
// paddsb_seq_ctrl: packed saturating add/subtract over LANES 4-bit signed
// lanes, computed one lane per cycle through a single shared paddsb_lane.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - paddsb_seq_ctrl_if.slave (in/out handshakes, A, B, sub, Sum,
//           and sat_flags when PADDSB_SAT_FLAG_EN is defined)
// Optional feature macro: PADDSB_SAT_FLAG_EN (per-lane saturation flags).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1, waiting for in_valid
// CALC  | one lane per cycle, lane cnt_q, operands held in a_q/b_q/sub_q
// DONE  | out_valid=1, Sum held until out_ready
module paddsb_seq_ctrl
  import paddsb_pkg::*;
#(
  parameter int LANES = 4
) (
  input logic             clk,
  input logic             rst_n,
  paddsb_seq_ctrl_if.slave bus
);

  localparam int W     = LANE_W * LANES;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [W-1:0]      a_q, b_q, sum_q;
  logic              sub_q;
  logic [LANE_W-1:0] lane_a, lane_b, lane_y;
  logic              lane_sat;
  logic              accept, last_lane;

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign last_lane = (cnt_q == CNT_W'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CALC;
      CALC:    if (last_lane)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Sum       = sum_q;

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        lane_a = a_q[i*LANE_W +: LANE_W];
        lane_b = b_q[i*LANE_W +: LANE_W];
      end
    end
  end

  paddsb_lane u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .sub (sub_q),
    .y   (lane_y),
    .sat (lane_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
    end else if (accept) begin
      a_q   <= bus.A;
      b_q   <= bus.B;
      sub_q <= bus.sub;
      cnt_q <= '0;
    end else if (state_q == CALC) begin
      for (int i = 0; i < LANES; i++) begin
        if (cnt_q == CNT_W'(i)) sum_q[i*LANE_W +: LANE_W] <= lane_y;
      end
      // Wrap explicitly so non-power-of-two LANES never leaves the range.
      cnt_q <= last_lane ? '0 : cnt_q + 1'b1;
    end
  end

`ifdef PADDSB_SAT_FLAG_EN
  logic [LANES-1:0] sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= '0;
    end else if (state_q == CALC) begin
      for (int i = 0; i < LANES; i++) begin
        if (cnt_q == CNT_W'(i)) sat_q[i] <= lane_sat;
      end
    end
  end

  assign bus.sat_flags = sat_q;
`else
  logic unused_sat;
  assign unused_sat = lane_sat;
`endif

endmodule

// File: tb/tb_paddsb_seq_ctrl.sv
// tb_paddsb_seq_ctrl: self-checking bench for paddsb_seq_ctrl. Directed
// scenarios plus randomized operations, checked against an integer-level
// saturating-arithmetic model.
module tb_paddsb_seq_ctrl;
  localparam int LANES = 4;
  localparam int W     = 4 * LANES;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  paddsb_seq_ctrl_if #(.LANES(LANES)) bus ();

  paddsb_seq_ctrl #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each lane as a signed integer, exact sum/difference,
  // clamped to the 4-bit signed range.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, output logic [LANES-1:0] flags);
    logic [W-1:0] res;
    logic [3:0]   la, lb;
    int x, y, r;
    res   = '0;
    flags = '0;
    for (int i = 0; i < LANES; i++) begin
      la = a[i*4 +: 4];
      lb = b[i*4 +: 4];
      x  = int'($signed(la));
      y  = int'($signed(lb));
      r  = s ? x - y : x + y;
      if (r > 7) begin
        r = 7;
        flags[i] = 1'b1;
      end else if (r < -8) begin
        r = -8;
        flags[i] = 1'b1;
      end
      res[i*4 +: 4] = 4'(r);
    end
    return res;
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency and result, optionally stalls in
  // DONE, then completes with in_valid also high to confirm no same-cycle
  // re-accept.
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input int stall, input bit toggle, input string tag);
    logic [W-1:0]     exp_sum;
    logic [LANES-1:0] exp_flags;
    int cyc;
    exp_sum = model(a, b, s, exp_flags);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      if (toggle) begin
        bus.A   = W'($urandom);
        bus.B   = W'($urandom);
        bus.sub = 1'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LANES));
    check({tag, "_sum"}, 32'(bus.Sum), 32'(exp_sum));
`ifdef PADDSB_SAT_FLAG_EN
    check({tag, "_sat_flags"}, 32'(bus.sat_flags), 32'(exp_flags));
`endif
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_stall_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_stall_sum"}, 32'(bus.Sum), 32'(exp_sum));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, "_exit_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_no_reaccept"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_sum_held"}, 32'(bus.Sum), 32'(exp_sum));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int stall, input bit toggle, input string tag);
    start_op(a, b, s);
    finish_op(a, b, s, stall, toggle, tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", 32'(bus.Sum), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PADDSB_SAT_FLAG_EN
    check("rst_sat_flags", 32'(bus.sat_flags), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h1111, 1'b0, 0, 1'b0, "s1_add");
    run_op(16'h7777, 16'h1111, 1'b0, 0, 1'b0, "s2_pos_sat");
    run_op(16'h8888, 16'h8888, 1'b0, 0, 1'b0, "s2_neg_sat");
    run_op(16'h4444, 16'h1111, 1'b1, 0, 1'b0, "s3_sub");
    run_op(16'h7777, 16'h8888, 1'b1, 0, 1'b0, "s3_sub_pos_sat");
    run_op(16'h8888, 16'h7777, 1'b1, 0, 1'b0, "s3_sub_neg_sat");
    run_op(16'h7F80, 16'h0180, 1'b0, 5, 1'b0, "s4_stall");
    run_op(16'h3A5C, 16'hC6B1, 1'b1, 0, 1'b1, "s5_toggle");

    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("s6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("s6_rst_sum", 32'(bus.Sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("s6_in_ready", 32'(bus.in_ready), 32'd1);
    run_op(16'h1234, 16'h1111, 1'b0, 0, 1'b0, "s6_after_rst");

    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, int'($urandom_range(0, 2)), 1'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
